data_mem_param: RTL and testbench
=================================

DATA_MEM_PARAM -- requirements
Module: data_mem_param

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DEPTH_WORDS, 1024: data words stored; power of two, 16..4096.
- LED_ADDR, 32'h2000: byte address of the memory-mapped LED register.
- LED_WIDTH, 8: width of the led output; 1..32.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state changes on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- addr, in, 32: byte address.
- write_data, in, 32: store data, right-aligned.
- memwrite, in, 1: store request.
- memread, in, 1: load request.
- sign_mask, in, 4: access size and sign (REQ-004).
- read_data, out, 32: registered load result.
- led, out, LED_WIDTH: led_reg[LED_WIDTH-1:0].
- clk_stall, out, 1: high while a read-modify-write is in progress; upstream holds its inputs.
- misalign_err, out, 1: one-cycle pulse on a rejected access.
- range_err, out, 1: one-cycle pulse on an out-of-range access.

Function
REQ-003 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; byte offset SHALL be addr[1:0].

REQ-004 sign_mask SHALL decode as follows:
- bit2=1: word.
- bit2=0, bit1=1: halfword.
- otherwise: byte.
- bit3=1: sign-extend loads; bit3=0: zero-extend loads.

REQ-005 The FSM SHALL have states IDLE and RMW, with these transitions:
- IDLE -> RMW on an accepted aligned sub-word store.
- RMW -> IDLE unconditionally after one cycle.

REQ-006 In IDLE the block SHALL accept a request every cycle; in RMW all inputs SHALL be ignored.

REQ-007 An aligned word store in IDLE SHALL write memory on the same edge, with no stall.

REQ-008 An aligned byte/halfword store SHALL proceed as follows:
- Edge 1: latch the old word, the address and the data, then enter RMW; clk_stall=1 for exactly that one cycle.
- Edge 2: write the merged word, in which only the addressed byte or halfword is replaced.

REQ-009 A load in IDLE SHALL present read_data on the following edge, extracted per offset and extended per bit3; read latency SHALL be 1 cycle.

REQ-010 read_data SHALL hold its value until the next accepted load.

REQ-011 memread and memwrite both high SHALL be treated as a load only; the store SHALL be discarded without error.

REQ-012 Misalignment SHALL be handled as follows:
- Misaligned means a halfword with addr[0]=1, or a word with addr[1:0]!=0.
- A misaligned store SHALL not write memory.
- A misaligned load SHALL return 32'h0.
- Either case SHALL pulse misalign_err for 1 cycle.

REQ-013 Address range SHALL be handled as follows:
- addr >= 4*DEPTH_WORDS and addr != LED_ADDR is out of range.
- An out-of-range store SHALL be dropped.
- An out-of-range load SHALL return 32'h0.
- Either case SHALL pulse range_err for 1 cycle.
- When both misalign and range errors apply, only misalign_err SHALL pulse.

REQ-014 A store to LED_ADDR SHALL update led_reg with write_data, regardless of size, on the accepting edge without stall; it SHALL not write the data array.

REQ-015 A load from LED_ADDR SHALL return led_reg zero-extended to 32 bits.

REQ-016 A load issued the cycle after RMW completes SHALL return the merged word, with no stale data.

Reset
REQ-017 While reset=1 on a clock edge, the block SHALL:
- force the state to IDLE;
- set clk_stall=0, read_data=0, led_reg=0, misalign_err=0 and range_err=0.

REQ-018 Reset asserted during RMW SHALL abort the pending write, leaving the memory word unchanged.

REQ-019 Data array contents SHALL be unaffected by reset and SHALL be undefined after power-up.

Verification
REQ-020 Word store then load:
- Stimulus: store word 32'hDEADBEEF @0x10, then load word @0x10.
- Response: read_data=32'hDEADBEEF one cycle after the load; clk_stall never asserted.

REQ-021 Byte RMW:
- Stimulus: after REQ-020, store byte 8'h80 @0x13, then load signed byte @0x13 and load word @0x10.
- Response: clk_stall high for 1 cycle; signed byte load returns 32'hFFFFFF80; word load returns 32'h80ADBEEF.

REQ-022 Halfword merge:
- Stimulus: store halfword 16'h1234 @0x12, then load unsigned halfword @0x12.
- Response: returns 32'h00001234; bytes @0x10-0x11 unchanged.

REQ-023 Misaligned and out-of-range access:
- Stimulus: load word @0x11, then store @4*DEPTH_WORDS.
- Response: misalign_err pulses 1 cycle with read_data=0; range_err pulses 1 cycle with memory unchanged.

REQ-024 LED register:
- Stimulus: store 32'h000000A5 @LED_ADDR, then load @LED_ADDR.
- Response: led=8'hA5; read_data=32'h000000A5; the data array is not written.

REQ-025 Reset during RMW:
- Stimulus: assert reset in the RMW cycle of a byte store @0x20.
- Response: word @0x20 is unchanged; clk_stall=0 and the FSM is in IDLE on the next cycle.

Source files
------------

// File: rtl/data_mem_param.sv
// Data memory with a memory-mapped LED register.
// Handles byte/halfword/word loads and stores with a registered read port,
// misalignment and range checking. Sub-word stores use a one-cycle
// read-modify-write, during which clk_stall is high and inputs are ignored.
module data_mem_param #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] LED_ADDR    = 32'h2000,
    parameter int          LED_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          addr,
    input  logic [31:0]          write_data,
    input  logic                 memwrite,
    input  logic                 memread,
    input  logic [3:0]           sign_mask,
    output logic [31:0]          read_data,
    output logic [LED_WIDTH-1:0] led,
    output logic                 clk_stall,
    output logic                 misalign_err,
    output logic                 range_err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);

    typedef enum logic {
        IDLE,
        RMW
    } state_t;

    state_t state_q, state_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]          read_data_q, read_data_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic                 misalign_q, misalign_d;
    logic                 range_q, range_d;

    // Latched read-modify-write context
    logic [31:0]   old_q, old_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]    off_q, off_d;
    logic          half_q, half_d;

    // Request decode
    logic          is_word, is_half, misalign, is_led, out_range;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word, shifted, load_val, merged, led_ext;

    // Memory write port
    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [31:0]   mem_wdata;

    // Decode the incoming request and extract the addressed load value
    always_comb begin
        is_word   = sign_mask[2];
        is_half   = ~sign_mask[2] & sign_mask[1];
        misalign  = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
        is_led    = (addr == LED_ADDR);
        out_range = (addr >= MEM_BYTES) & ~is_led;
        idx       = addr[AW+1:2];
        rd_word   = mem[idx];
        // Aligned halfwords have addr[0]=0, so a byte-granular shift is valid for them too
        shifted   = rd_word >> {addr[1:0], 3'b000};
        if (is_word) begin
            load_val = rd_word;
        end else if (is_half) begin
            load_val = {{16{sign_mask[3] & shifted[15]}}, shifted[15:0]};
        end else begin
            load_val = {{24{sign_mask[3] & shifted[7]}}, shifted[7:0]};
        end
        led_ext                  = '0;
        led_ext[LED_WIDTH-1:0]   = led_q;
    end

    // Merge the latched store data into the latched old word
    always_comb begin
        merged = old_q;
        if (half_q) begin
            merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end else begin
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    // Next-state, output and memory-write control
    always_comb begin
        state_d     = state_q;
        read_data_d = read_data_q;
        led_d       = led_q;
        misalign_d  = 1'b0;
        range_d     = 1'b0;
        old_d       = old_q;
        wdata_d     = wdata_q;
        idx_d       = idx_q;
        off_d       = off_q;
        half_d      = half_q;
        mem_we      = 1'b0;
        mem_widx    = idx;
        mem_wdata   = write_data;

        case (state_q)
            IDLE: begin
                if (memread | memwrite) begin
                    if (misalign) begin
                        misalign_d = 1'b1;
                    end else if (out_range) begin
                        range_d = 1'b1;
                    end

                    if (memread) begin
                        // A simultaneous store is discarded
                        if (misalign | out_range) begin
                            read_data_d = '0;
                        end else if (is_led) begin
                            read_data_d = led_ext;
                        end else begin
                            read_data_d = load_val;
                        end
                    end else if (~misalign & ~out_range) begin
                        if (is_led) begin
                            led_d = write_data[LED_WIDTH-1:0];
                        end else if (is_word) begin
                            mem_we = 1'b1;
                        end else begin
                            old_d   = rd_word;
                            wdata_d = write_data;
                            idx_d   = idx;
                            off_d   = addr[1:0];
                            half_d  = is_half;
                            state_d = RMW;
                        end
                    end
                end
            end
            RMW: begin
                mem_we    = 1'b1;
                mem_widx  = idx_q;
                mem_wdata = merged;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset aborts any write, including a pending merge
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            read_data_q <= '0;
            led_q       <= '0;
            misalign_q  <= 1'b0;
            range_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_data_q <= read_data_d;
            led_q       <= led_d;
            misalign_q  <= misalign_d;
            range_q     <= range_d;
        end
    end

    // Read-modify-write context registers, no reset needed
    always_ff @(posedge clk) begin
        old_q   <= old_d;
        wdata_q <= wdata_d;
        idx_q   <= idx_d;
        off_q   <= off_d;
        half_q  <= half_d;
    end

    // Data array write port; contents are not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    assign read_data    = read_data_q;
    assign led          = led_q;
    assign clk_stall    = (state_q == RMW);
    assign misalign_err = misalign_q;
    assign range_err    = range_q;

endmodule

// File: tb/tb_data_mem_param.sv
// Testbench for data_mem_param: directed scenarios followed by random
// traffic, checked against a byte-addressed reference model.
module tb_data_mem_param;

    localparam int          DEPTH  = 1024;
    localparam logic [31:0] LEDA   = 32'h2000;
    localparam int          LW     = 8;
    localparam int          NBYTES = 4 * DEPTH;

    localparam logic [3:0] SM_B  = 4'b0001;
    localparam logic [3:0] SM_SB = 4'b1001;
    localparam logic [3:0] SM_H  = 4'b0010;
    localparam logic [3:0] SM_W  = 4'b0100;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   addr;
    logic [31:0]   write_data;
    logic          memwrite;
    logic          memread;
    logic [3:0]    sign_mask;
    logic [31:0]   read_data;
    logic [LW-1:0] led;
    logic          clk_stall;
    logic          misalign_err;
    logic          range_err;

    data_mem_param #(
        .DEPTH_WORDS(DEPTH),
        .LED_ADDR   (LEDA),
        .LED_WIDTH  (LW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .write_data  (write_data),
        .memwrite    (memwrite),
        .memread     (memread),
        .sign_mask   (sign_mask),
        .read_data   (read_data),
        .led         (led),
        .clk_stall   (clk_stall),
        .misalign_err(misalign_err),
        .range_err   (range_err)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model: byte-addressed little-endian memory, LED value, last load
    logic [7:0]    mb [NBYTES];
    logic [31:0]   rd_m;
    logic [LW-1:0] led_m;

    task automatic chk(input string tag, input string field,
                       input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit e_mis, input bit e_rng, input bit e_stall);
        chk(tag, "rdata", read_data, rd_m);
        chk(tag, "misalign", 32'(misalign_err), 32'(e_mis));
        chk(tag, "range", 32'(range_err), 32'(e_rng));
        chk(tag, "stall", 32'(clk_stall), 32'(e_stall));
        chk(tag, "led", 32'(led), 32'(led_m));
    endtask

    // One request in IDLE; if it starts a merge, the following cycle either
    // drives random junk (must be ignored) or asserts reset (abort).
    task automatic op(input logic rd, input logic wr, input logic [3:0] sm,
                      input logic [31:0] a, input logic [31:0] wd,
                      input bit abort, input string tag);
        int unsigned size;
        bit          mis, oor, isled, stall, e_mis, e_rng;
        logic [31:0] v;
        size  = sm[2] ? 4 : (sm[1] ? 2 : 1);
        mis   = (a % size) != 0;
        isled = (a == LEDA);
        oor   = (a >= NBYTES) && !isled;
        stall = 1'b0;
        e_mis = (rd || wr) && mis;
        e_rng = (rd || wr) && !mis && oor;
        if (rd) begin
            if (mis || oor) begin
                rd_m = '0;
            end else if (isled) begin
                rd_m = 32'(led_m);
            end else begin
                v = '0;
                for (int unsigned i = 0; i < size; i++) v |= 32'(mb[a + i]) << (8 * i);
                if (sm[3] && size < 4 && v[8 * size - 1]) v |= ~((32'd1 << (8 * size)) - 32'd1);
                rd_m = v;
            end
        end else if (wr && !mis && !oor) begin
            if (isled) begin
                led_m = wd[LW-1:0];
            end else begin
                stall = (size < 4);
                if (!(stall && abort))
                    for (int unsigned i = 0; i < size; i++) mb[a + i] = wd[8 * i +: 8];
            end
        end

        @(negedge clk);
        memread    = rd;
        memwrite   = wr;
        sign_mask  = sm;
        addr       = a;
        write_data = wd;
        @(posedge clk);
        #1;
        chk_all(tag, e_mis, e_rng, stall);

        if (stall) begin
            @(negedge clk);
            if (abort) begin
                memread  = 1'b0;
                memwrite = 1'b0;
                reset    = 1'b1;
            end else begin
                memread    = 1'($urandom);
                memwrite   = 1'($urandom);
                sign_mask  = 4'($urandom);
                addr       = $urandom % 64;
                write_data = $urandom;
            end
            @(posedge clk);
            #1;
            if (abort) begin
                rd_m  = '0;
                led_m = '0;
            end
            chk_all({tag, "_rmw"}, 1'b0, 1'b0, 1'b0);
            reset = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] a;
        int unsigned r;

        reset      = 1'b1;
        memread    = 1'b0;
        memwrite   = 1'b0;
        sign_mask  = '0;
        addr       = '0;
        write_data = '0;
        rd_m       = '0;
        led_m      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Give every word the random traffic can touch a known value
        for (int unsigned w = 0; w < 16; w++) op(1'b0, 1'b1, SM_W, 4 * w, $urandom, 1'b0, "init");
        op(1'b0, 1'b1, SM_W, NBYTES - 4, $urandom, 1'b0, "init_top");

        op(1'b0, 1'b1, SM_W, 32'h10, 32'hDEADBEEF, 1'b0, "st_word");
        op(1'b1, 1'b0, SM_W, 32'h10, '0, 1'b0, "ld_word");
        chk("ld_word", "const", read_data, 32'hDEADBEEF);

        op(1'b0, 1'b1, SM_B, 32'h13, 32'h00000080, 1'b0, "st_byte");
        op(1'b1, 1'b0, SM_SB, 32'h13, '0, 1'b0, "ld_sbyte");
        chk("ld_sbyte", "const", read_data, 32'hFFFFFF80);
        op(1'b1, 1'b0, SM_W, 32'h10, '0, 1'b0, "ld_merged");
        chk("ld_merged", "const", read_data, 32'h80ADBEEF);

        op(1'b0, 1'b1, SM_H, 32'h12, 32'h00001234, 1'b0, "st_half");
        op(1'b1, 1'b0, SM_H, 32'h12, '0, 1'b0, "ld_uhalf");
        chk("ld_uhalf", "const", read_data, 32'h00001234);
        op(1'b1, 1'b0, SM_W, 32'h10, '0, 1'b0, "ld_half_word");
        chk("ld_half_word", "const", read_data, 32'h1234BEEF);

        op(1'b1, 1'b0, SM_W, 32'h11, '0, 1'b0, "ld_misalign");
        op(1'b0, 1'b1, SM_W, NBYTES, 32'h55555555, 1'b0, "st_range");
        op(1'b1, 1'b0, SM_W, 32'h0, '0, 1'b0, "ld_after_range");
        op(1'b1, 1'b0, SM_H, NBYTES + 1, '0, 1'b0, "ld_both_err");

        op(1'b0, 1'b1, SM_W, LEDA, 32'h000000A5, 1'b0, "st_led");
        chk("st_led", "const", 32'(led), 32'h000000A5);
        op(1'b1, 1'b0, SM_W, LEDA, '0, 1'b0, "ld_led");
        chk("ld_led", "const", read_data, 32'h000000A5);
        op(1'b1, 1'b0, SM_W, 32'h0, '0, 1'b0, "ld_led_alias");

        op(1'b1, 1'b1, SM_W, 32'h14, 32'hCAFEF00D, 1'b0, "rd_wr_both");
        op(1'b1, 1'b0, SM_W, 32'h14, '0, 1'b0, "ld_after_both");

        op(1'b0, 1'b1, SM_B, 32'h20, 32'h000000FF, 1'b1, "rmw_abort");
        op(1'b1, 1'b0, SM_W, 32'h20, '0, 1'b0, "ld_after_abort");

        for (int unsigned n = 0; n < 400; n++) begin
            r = $urandom % 10;
            if (r < 8)       a = $urandom % 64;
            else if (r == 8) a = NBYTES - 4 + ($urandom % 8);
            else             a = LEDA + (($urandom % 2) != 0 ? ($urandom % 4) : 0);
            op(1'($urandom), 1'($urandom), 4'($urandom), a, $urandom,
               ($urandom % 20) == 0, "rand");
        end

        @(negedge clk);
        memread  = 1'b0;
        memwrite = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
